// File: rtl/piso_serializer_if.sv
// piso_serializer_if
//   Bundles the parallel word handshake and the framed serial output of the
//   serializer so that source and serializer connect through one port.
//   Ports (signals):
//     din        [WIDTH]  parallel word offered by the source
//     din_valid           din holds a valid word
//     din_ready           serializer can accept a word this cycle
//     dout                serial data bit
//     dout_valid          dout carries a word bit this cycle
//     sof / eof           first / last bit of a word
//     busy                serializer is sending or holding a word
//   Modports:
//     master - the word source (drives din/din_valid, observes the rest)
//     slave  - the serializer itself
interface piso_serializer_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             dout;
    logic             dout_valid;
    logic             sof;
    logic             eof;
    logic             busy;

    modport master (
        output din,
        output din_valid,
        input  din_ready,
        input  dout,
        input  dout_valid,
        input  sof,
        input  eof,
        input  busy
    );

    modport slave (
        input  din,
        input  din_valid,
        output din_ready,
        output dout,
        output dout_valid,
        output sof,
        output eof,
        output busy
    );
endinterface

// File: rtl/piso_serializer.sv
// piso_serializer
//   Parallel-in serial-out serializer. Accepts WIDTH-bit words over a
//   valid/ready handshake and sends them one bit per clock, framed by sof/eof.
//   A one-word holding buffer lets consecutive words stream with no idle cycle.
//   Ports:
//     clk   - system clock, all state changes on the rising edge
//     rst   - synchronous active-high reset
//     bus   - piso_serializer_if.slave: din/din_valid/din_ready handshake,
//             dout/dout_valid/sof/eof/busy serial side
//   Parameters:
//     WIDTH     - word width (>= 2)
//     MSB_FIRST - 1: bit WIDTH-1 goes out first, 0: bit 0 goes out first
module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    piso_serializer_if.slave    bus
);
    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [0:0]       state_reg,     state_next;
    logic [CNT_W-1:0] bit_cnt_reg,   bit_cnt_next;
    logic [WIDTH-1:0] shift_reg,     shift_next;
    logic [WIDTH-1:0] hold_reg,      hold_next;
    logic             hold_full_reg, hold_full_next;

    logic [WIDTH-1:0] shift_adv;
    logic             din_ready_int;
    logic             accept;
    logic             shifter_free;

    // Shift register advanced by one bit toward the output end; the vacated
    // end fills with zero so the register is all-zero after the last bit.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_adv
            if (MSB_FIRST) begin : g_msb
                if (gi == 0) begin : g_fill
                    assign shift_adv[gi] = 1'b0;
                end else begin : g_move
                    assign shift_adv[gi] = shift_reg[gi-1];
                end
            end else begin : g_lsb
                if (gi == WIDTH - 1) begin : g_fill
                    assign shift_adv[gi] = 1'b0;
                end else begin : g_move
                    assign shift_adv[gi] = shift_reg[gi+1];
                end
            end
        end
    endgenerate

    // Ready only depends on the hold buffer: the shifter can always take a
    // word through the hold path, so a free hold slot is enough to accept.
    assign din_ready_int = ~hold_full_reg & ~rst;
    assign accept        = bus.din_valid & din_ready_int;
    assign shifter_free  = (state_reg == ST_IDLE) || (bit_cnt_reg == LAST_CNT);

    always_comb begin
        state_next     = state_reg;
        bit_cnt_next   = bit_cnt_reg;
        shift_next     = shift_reg;
        hold_next      = hold_reg;
        hold_full_next = hold_full_reg;

        if (shifter_free) begin
            bit_cnt_next = '0;
            if (hold_full_reg) begin
                // din_ready is low here, so no accept can collide with the drain
                shift_next     = hold_reg;
                hold_full_next = 1'b0;
                state_next     = ST_SHIFT;
            end else if (accept) begin
                shift_next = bus.din;
                state_next = ST_SHIFT;
            end else begin
                shift_next = '0;
                state_next = ST_IDLE;
            end
        end else begin
            shift_next   = shift_adv;
            bit_cnt_next = bit_cnt_reg + CNT_W'(1);
            if (accept) begin
                hold_next      = bus.din;
                hold_full_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            hold_reg      <= '0;
            hold_full_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            bit_cnt_reg   <= bit_cnt_next;
            shift_reg     <= shift_next;
            hold_reg      <= hold_next;
            hold_full_reg <= hold_full_next;
        end
    end

    // dout is taken straight from the output end of the shift register, which
    // is cleared whenever the shifter goes idle, so dout=0 outside a word.
    assign bus.din_ready  = din_ready_int;
    assign bus.dout       = MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0];
    assign bus.dout_valid = (state_reg == ST_SHIFT);
    assign bus.sof        = (state_reg == ST_SHIFT) && (bit_cnt_reg == '0);
    assign bus.eof        = (state_reg == ST_SHIFT) && (bit_cnt_reg == LAST_CNT);
    assign bus.busy       = (state_reg == ST_SHIFT) | hold_full_reg;
endmodule

// File: tb/tb_piso_serializer.sv
module tb_piso_serializer;
    logic clk;
    logic rst;

    piso_serializer_if #(.WIDTH(4)) ifm ();
    piso_serializer_if #(.WIDTH(4)) ifl ();

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
        .clk (clk),
        .rst (rst),
        .bus (ifm)
    );

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
        .clk (clk),
        .rst (rst),
        .bus (ifl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Simple deserializer on the LSB-first instance: bits arrive LSB first,
    // so each new bit enters at the top and the word is complete on eof.
    logic [3:0] sipo_sh;
    logic [3:0] sipo_word;
    int         sipo_cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            sipo_sh   <= '0;
            sipo_word <= '0;
            sipo_cnt  <= 0;
        end else if (ifl.dout_valid) begin
            sipo_sh <= {ifl.dout, sipo_sh[3:1]};
            if (ifl.eof) begin
                sipo_word <= {ifl.dout, sipo_sh[3:1]};
                sipo_cnt  <= sipo_cnt + 1;
            end
        end
    end

    // Per-cycle vector: inputs applied before the edge, din_ready expected
    // before the edge, outputs {dout,dout_valid,sof,eof,busy} expected after.
    typedef struct {
        logic       r;
        logic       v;
        logic [3:0] d;
        logic       rdy;
        logic [4:0] o;
    } vec_t;

    vec_t vq[$];

    task automatic addv(input logic r, input logic v, input logic [3:0] d,
                        input logic rdy, input logic [4:0] o);
        vec_t t;
        t.r = r; t.v = v; t.d = d; t.rdy = rdy; t.o = o;
        vq.push_back(t);
    endtask

    function automatic logic [4:0] outs_m();
        return {ifm.dout, ifm.dout_valid, ifm.sof, ifm.eof, ifm.busy};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0] bits;
        int         nbits;
        logic       got_eof;
        logic       sof_first;
        int         cnt_before;

        rst = 1'b1;
        ifm.din = '0; ifm.din_valid = 1'b0;
        ifl.din = '0; ifl.din_valid = 1'b0;

        // reset
        addv(1, 0, 4'h0, 0, 5'b00000);
        addv(1, 0, 4'h0, 0, 5'b00000);
        addv(0, 0, 4'h0, 1, 5'b00000);
        // single word 1010
        addv(0, 1, 4'hA, 1, 5'b11101);
        addv(0, 0, 4'h0, 1, 5'b01001);
        addv(0, 0, 4'h0, 1, 5'b11001);
        addv(0, 0, 4'h0, 1, 5'b01011);
        addv(0, 0, 4'h0, 1, 5'b00000);
        // 1100 then 0011, second goes through hold
        addv(0, 1, 4'hC, 1, 5'b11101);
        addv(0, 1, 4'h3, 1, 5'b11001);
        addv(0, 0, 4'h0, 0, 5'b01001);
        addv(0, 0, 4'h0, 0, 5'b01011);
        addv(0, 0, 4'h0, 0, 5'b01101);
        addv(0, 0, 4'h0, 1, 5'b01001);
        addv(0, 0, 4'h0, 1, 5'b11001);
        addv(0, 0, 4'h0, 1, 5'b11011);
        addv(0, 0, 4'h0, 1, 5'b00000);
        // A, 5, F with valid held; F waits for hold to drain
        addv(0, 1, 4'hA, 1, 5'b11101);
        addv(0, 1, 4'h5, 1, 5'b01001);
        addv(0, 1, 4'hF, 0, 5'b11001);
        addv(0, 1, 4'hF, 0, 5'b01011);
        addv(0, 1, 4'hF, 0, 5'b01101);
        addv(0, 1, 4'hF, 1, 5'b11001);
        addv(0, 0, 4'h0, 0, 5'b01001);
        addv(0, 0, 4'h0, 0, 5'b11011);
        addv(0, 0, 4'h0, 0, 5'b11101);
        addv(0, 0, 4'h0, 1, 5'b11001);
        addv(0, 0, 4'h0, 1, 5'b11001);
        addv(0, 0, 4'h0, 1, 5'b11011);
        addv(0, 0, 4'h0, 1, 5'b00000);

        foreach (vq[i]) begin
            rst           = vq[i].r;
            ifm.din_valid = vq[i].v;
            ifm.din       = vq[i].d;
            #1;
            chk($sformatf("vec%0d din_ready", i), {7'd0, ifm.din_ready}, {7'd0, vq[i].rdy});
            step();
            chk($sformatf("vec%0d outs", i), {3'd0, outs_m()}, {3'd0, vq[i].o});
            $display("vec %0d: rst=%0b valid=%0b din=%h ready=%0b outs=%b", i,
                     vq[i].r, vq[i].v, vq[i].d, ifm.din_ready, outs_m());
        end

        // Reset in the middle of a word, then a fresh word
        ifm.din = 4'hF; ifm.din_valid = 1'b1;
        step();
        chk("abort first bit", {3'd0, outs_m()}, 8'b000_11101);
        ifm.din_valid = 1'b0;
        step();
        chk("abort second bit", {3'd0, outs_m()}, 8'b000_11001);
        rst = 1'b1;
        #1;
        chk("abort ready in rst", {7'd0, ifm.din_ready}, 8'd0);
        step();
        chk("abort after rst", {3'd0, outs_m()}, 8'b000_00000);
        rst = 1'b0;
        ifm.din = 4'b0110; ifm.din_valid = 1'b1;
        #1;
        chk("restart ready", {7'd0, ifm.din_ready}, 8'd1);
        step();
        ifm.din_valid = 1'b0;
        bits = '0; nbits = 0; got_eof = 1'b0; sof_first = 1'b0;
        for (int k = 0; k < 10 && !got_eof; k++) begin
            if (ifm.dout_valid) begin
                if (nbits == 0) sof_first = ifm.sof;
                bits = {bits[2:0], ifm.dout};
                nbits++;
                if (ifm.eof) got_eof = 1'b1;
            end
            if (!got_eof) step();
        end
        chk("restart eof seen", {7'd0, got_eof}, 8'd1);
        chk("restart sof first", {7'd0, sof_first}, 8'd1);
        chk("restart bit count", 8'(nbits), 8'd4);
        chk("restart bits", {4'd0, bits}, 8'b0000_0110);
        $display("restart word: bits=%b count=%0d", bits, nbits);
        step();
        chk("restart idle", {3'd0, outs_m()}, 8'b000_00000);

        // LSB-first instance into the deserializer model
        for (int w = 0; w < 2; w++) begin
            logic [3:0] word;
            logic [3:0] exp_seq;
            word    = (w == 0) ? 4'b0001 : 4'b1101;
            exp_seq = (w == 0) ? 4'b1000 : 4'b1011;
            cnt_before = sipo_cnt;
            ifl.din = word; ifl.din_valid = 1'b1;
            #1;
            chk($sformatf("lsb w%0d ready", w), {7'd0, ifl.din_ready}, 8'd1);
            step();
            ifl.din_valid = 1'b0;
            bits = '0; nbits = 0; got_eof = 1'b0;
            for (int k = 0; k < 10 && !got_eof; k++) begin
                if (ifl.dout_valid) begin
                    bits = {bits[2:0], ifl.dout};
                    nbits++;
                    if (ifl.eof) got_eof = 1'b1;
                end
                step();
            end
            chk($sformatf("lsb w%0d eof seen", w), {7'd0, got_eof}, 8'd1);
            chk($sformatf("lsb w%0d serial order", w), {4'd0, bits}, {4'd0, exp_seq});
            chk($sformatf("lsb w%0d sipo count", w), 8'(sipo_cnt - cnt_before), 8'd1);
            chk($sformatf("lsb w%0d sipo word", w), {4'd0, sipo_word}, {4'd0, word});
            $display("lsb word %0d: sent=%b serial=%b sipo=%b", w, word, bits, sipo_word);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
